// File: rtl/tri_raster_sched.sv
// Round-robin scheduler feeding triangle jobs from two requesters to one scanline rasterizer.
// Define VERTEX_SORT_EN to reorder vertices by ascending x before the job starts.
module tri_raster_sched #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [95:0]      req0_tri,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [95:0]      req1_tri,
  output logic             req1_ready,
  output logic [15:0]      rast_x0,
  output logic [15:0]      rast_y0,
  output logic [15:0]      rast_x1,
  output logic [15:0]      rast_y1,
  output logic [15:0]      rast_x2,
  output logic [15:0]      rast_y2,
  output logic             rast_start,
  input  logic             rast_done,
  output logic             busy,
  output logic             grant_id,
  output logic             job_done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] tri_count
);

  typedef enum logic [2:0] {IDLE, SORT, LOAD, START, ACK, RUN} state_t;

  state_t      state;
  logic        last_grant;
  logic [15:0] vx [3];
  logic [15:0] vy [3];
  logic [23:0] timer;
  logic        win0;
  logic        win1;
  logic        tmo_hit;
  logic [95:0] sel_tri;
`ifdef VERTEX_SORT_EN
  logic [1:0]  sort_step;
`endif

  // On a tie the requester that did not win last time gets the grant.
  assign win0       = req0_valid && (!req1_valid || last_grant);
  assign win1       = req1_valid && (!req0_valid || !last_grant);
  assign req0_ready = (state == IDLE) && win0;
  assign req1_ready = (state == IDLE) && win1;
  assign sel_tri    = win1 ? req1_tri : req0_tri;
  assign busy       = (state != IDLE);
  assign tmo_hit    = (TIMEOUT_CYCLES != 24'd0) && (timer == TIMEOUT_CYCLES - 24'd1);

  assign rast_x0 = vx[0];
  assign rast_y0 = vy[0];
  assign rast_x1 = vx[1];
  assign rast_y1 = vy[1];
  assign rast_x2 = vx[2];
  assign rast_y2 = vy[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant_id    <= 1'b0;
      rast_start  <= 1'b0;
      job_done    <= 1'b0;
      timeout_err <= 1'b0;
      tri_count   <= '0;
      timer       <= '0;
      for (int i = 0; i < 3; i++) begin
        vx[i] <= '0;
        vy[i] <= '0;
      end
`ifdef VERTEX_SORT_EN
      sort_step   <= 2'd0;
`endif
    end else begin
      job_done   <= 1'b0;
      rast_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win0 || win1) begin
            vx[0]      <= sel_tri[95:80];
            vy[0]      <= sel_tri[79:64];
            vx[1]      <= sel_tri[63:48];
            vy[1]      <= sel_tri[47:32];
            vx[2]      <= sel_tri[31:16];
            vy[2]      <= sel_tri[15:0];
            last_grant <= win1;
            grant_id   <= win1;
`ifdef VERTEX_SORT_EN
            sort_step  <= 2'd0;
            state      <= SORT;
`else
            state      <= LOAD;
`endif
          end
        end
        SORT: begin
`ifdef VERTEX_SORT_EN
          // Three-step odd-even network; strict compare keeps equal-x vertices in order.
          if (sort_step == 2'd1) begin
            if (vx[1] > vx[2]) begin
              vx[1] <= vx[2];
              vx[2] <= vx[1];
              vy[1] <= vy[2];
              vy[2] <= vy[1];
            end
          end else if (vx[0] > vx[1]) begin
            vx[0] <= vx[1];
            vx[1] <= vx[0];
            vy[0] <= vy[1];
            vy[1] <= vy[0];
          end
          sort_step <= sort_step + 2'd1;
          if (sort_step == 2'd2) state <= LOAD;
`else
          state <= LOAD;
`endif
        end
        LOAD: begin
          rast_start <= 1'b1;
          state      <= START;
        end
        START: begin
          timer <= '0;
          state <= ACK;
        end
        ACK: begin
          // A done level left over from the previous job must drop before RUN.
          if (tmo_hit) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer + 24'd1;
            if (!rast_done) state <= RUN;
          end
        end
        RUN: begin
          if (rast_done) begin
            job_done  <= 1'b1;
            tri_count <= tri_count + CNT_W'(1);
            state     <= IDLE;
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer + 24'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_raster_sched.sv
// Bench for tri_raster_sched: table vectors, round-robin, stale done, random jobs,
// timeout and mid-job reset, against a behavioural rasterizer and reference model.
module tb_tri_raster_sched;
  localparam int          CNT_W = 16;
  localparam logic [23:0] TMO   = 24'd100;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [95:0]      req0_tri, req1_tri;
  logic             req0_ready, req1_ready;
  logic [15:0]      rast_x0, rast_y0, rast_x1, rast_y1, rast_x2, rast_y2;
  logic             rast_start;
  logic             rast_done = 1'b0;
  logic             busy, grant_id, job_done, timeout_err;
  logic [CNT_W-1:0] tri_count;
  logic [95:0]      bus;

  always #5 clk = ~clk;

  tri_raster_sched #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_tri(req0_tri), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_tri(req1_tri), .req1_ready(req1_ready),
    .rast_x0(rast_x0), .rast_y0(rast_y0), .rast_x1(rast_x1),
    .rast_y1(rast_y1), .rast_x2(rast_x2), .rast_y2(rast_y2),
    .rast_start(rast_start), .rast_done(rast_done),
    .busy(busy), .grant_id(grant_id), .job_done(job_done),
    .timeout_err(timeout_err), .tri_count(tri_count)
  );

  assign bus = {rast_x0, rast_y0, rast_x1, rast_y1, rast_x2, rast_y2};

  // Rasterizer model: accepts start only when idle, done is sticky.
  int          run_len   = 10;
  int          clr_delay = 0;
  bit          hang      = 1'b0;
  bit          r_run     = 1'b0;
  int          r_cnt     = 0;
  int          r_clr     = 0;
  logic [95:0] snap      = '0;
  int          moved_cnt = 0;

  always @(posedge clk) begin
    if (rast_start && !r_run) begin
      r_run <= 1'b1;
      r_cnt <= run_len;
      r_clr <= clr_delay;
      snap  <= bus;
      if (clr_delay == 0) rast_done <= 1'b0;
    end else if (r_run) begin
      if (bus != snap) moved_cnt <= moved_cnt + 1;
      if (r_clr > 0) begin
        r_clr <= r_clr - 1;
        if (r_clr == 1) rast_done <= 1'b0;
      end else if (!hang) begin
        if (r_cnt <= 1) begin
          rast_done <= 1'b1;
          r_run     <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 1;
        end
      end
    end
  end

  int start_cyc = 0;
  int jd_cnt    = 0;
  int both_rdy  = 0;
  always @(negedge clk) begin
    if (rast_start) start_cyc <= start_cyc + 1;
    if (job_done) jd_cnt <= jd_cnt + 1;
    if (req0_ready && req1_ready) both_rdy <= both_rdy + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;
  bit mdl_last  = 1'b1;
  int mdl_count = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [95:0] mk(input int x0, y0, x1, y1, x2, y2);
    return {16'(x0), 16'(y0), 16'(x1), 16'(y1), 16'(x2), 16'(y2)};
  endfunction

  // Stable ascending-x ordering computed by ranking each vertex.
  function automatic logic [95:0] ref_sort(input logic [95:0] t);
    logic [15:0] x [3];
    logic [15:0] y [3];
    logic [15:0] ox [3];
    logic [15:0] oy [3];
    for (int i = 0; i < 3; i++) begin
      x[i] = t[95-32*i -: 16];
      y[i] = t[79-32*i -: 16];
      ox[i] = x[i];
      oy[i] = y[i];
    end
`ifdef VERTEX_SORT_EN
    for (int i = 0; i < 3; i++) begin
      int rank = 0;
      for (int j = 0; j < 3; j++)
        if (x[j] < x[i] || (x[j] == x[i] && j < i)) rank++;
      ox[rank] = x[i];
      oy[rank] = y[i];
    end
`endif
    return {ox[0], oy[0], ox[1], oy[1], ox[2], oy[2]};
  endfunction

  function automatic logic [15:0] rnd_x();
    if ($urandom_range(0, 1) == 0) return 16'($urandom_range(0, 7));
    return 16'($urandom);
  endfunction

  function automatic logic [95:0] rnd_tri();
    return {rnd_x(), 16'($urandom), rnd_x(), 16'($urandom), rnd_x(), 16'($urandom)};
  endfunction

  // Called at a negedge; presents requests, waits for IDLE, checks ready, lets the transfer edge pass.
  task automatic issue(input bit v0, input bit v1, input logic [95:0] t0,
                       input logic [95:0] t1, output bit win);
    int guard = 0;
    req0_valid = v0;
    req1_valid = v1;
    req0_tri   = t0;
    req1_tri   = t1;
    while (busy && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_wait", 96'(guard < 500), 96'd1);
    #1;
    win = (v0 && v1) ? !mdl_last : v1;
    chk("ready", {94'd0, req1_ready, req0_ready}, win ? 96'd2 : 96'd1);
    @(posedge clk);
    mdl_last = win;
  endtask

  task automatic finish_job(input logic [95:0] exp_tri, input bit exp_gid,
                            input int st0_i, input int mv0_i, output int lat_o);
    int guard = 0;
    while (!job_done && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    lat_o = guard;
    chk("job_done_seen", 96'(job_done), 96'd1);
    mdl_count++;
    chk("vertices", bus, exp_tri);
    chk("grant_id", 96'(grant_id), 96'(exp_gid));
    chk("tri_count", 96'(tri_count), 96'(mdl_count));
    chk("start_pulses", 96'(start_cyc - st0_i), 96'd1);
    chk("bus_stable", 96'(moved_cnt - mv0_i), 96'd0);
  endtask

  typedef struct {
    logic [95:0] tri_in;
    bit          src;
    logic [95:0] sorted;
    int          rl;
  } vec_t;

  vec_t        vecs [5];
  bit          win;
  int          st0, mv0, lat, guard, n, jd0, exp_busy;
  logic [95:0] t0, t1, expv;
  bit          pend0, pend1;

  initial begin
    vecs[0] = '{mk(10, 5, 20, 30, 40, 5), 1'b0, mk(10, 5, 20, 30, 40, 5), 50};
    vecs[1] = '{mk(40, 5, 10, 5, 20, 30), 1'b1, mk(10, 5, 20, 30, 40, 5), 12};
    vecs[2] = '{mk(7, 1, 7, 2, 3, 9), 1'b0, mk(3, 9, 7, 1, 7, 2), 3};
    vecs[3] = '{mk(100, 1, 50, 2, 0, 3), 1'b1, mk(0, 3, 50, 2, 100, 1), 1};
    vecs[4] = '{mk(16'hFFFF, 1, 0, 2, 16'h8000, 3), 1'b0, mk(0, 2, 16'h8000, 3, 16'hFFFF, 1), 20};

    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_tri = '0;
    req1_tri = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {89'd0, busy, rast_start, job_done, timeout_err, grant_id,
                       req0_ready, req1_ready}, 96'd0);
    chk("reset_count", 96'(tri_count), 96'd0);
    chk("reset_bus", bus, 96'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_len = vecs[i].rl;
`ifdef VERTEX_SORT_EN
      expv = vecs[i].sorted;
`else
      expv = vecs[i].tri_in;
`endif
      st0 = start_cyc;
      mv0 = moved_cnt;
      issue(!vecs[i].src, vecs[i].src, vecs[i].tri_in, vecs[i].tri_in, win);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      finish_job(expv, vecs[i].src, st0, mv0, lat);
    end

    // Both requesters valid throughout: grants alternate 0,1,0,1 from reset.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_last = 1'b1;
    mdl_count = 0;
    run_len = 8;
    t0 = rnd_tri();
    t1 = rnd_tri();
    for (int k = 0; k < 4; k++) begin
      st0 = start_cyc;
      mv0 = moved_cnt;
      issue(1'b1, 1'b1, t0, t1, win);
      @(negedge clk);
      chk("ready_while_busy", {94'd0, req1_ready, req0_ready}, 96'd0);
      finish_job(ref_sort((k % 2) != 0 ? t1 : t0), (k % 2) != 0, st0, mv0, lat);
      if ((k % 2) != 0) t1 = rnd_tri();
      else t0 = rnd_tri();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Stale done: clear arrives two cycles after start is sampled.
    @(negedge clk);
    clr_delay = 2;
    run_len = 10;
    st0 = start_cyc;
    mv0 = moved_cnt;
    t0 = rnd_tri();
    issue(1'b1, 1'b0, t0, '0, win);
    @(negedge clk);
    req0_valid = 1'b0;
    finish_job(ref_sort(t0), 1'b0, st0, mv0, lat);
    chk("stale_ack_wait", 96'(lat > run_len), 96'd1);
    clr_delay = 0;

    // Random traffic; a losing requester keeps its request until served.
    pend0 = 1'b0;
    pend1 = 1'b0;
    for (int it = 0; it < 24; it++) begin
      if (!pend0 && $urandom_range(0, 1) == 1) begin pend0 = 1'b1; t0 = rnd_tri(); end
      if (!pend1 && $urandom_range(0, 1) == 1) begin pend1 = 1'b1; t1 = rnd_tri(); end
      if (!pend0 && !pend1) begin pend0 = 1'b1; t0 = rnd_tri(); end
      run_len = $urandom_range(1, 40);
      clr_delay = $urandom_range(0, 2);
      st0 = start_cyc;
      mv0 = moved_cnt;
      issue(pend0, pend1, t0, t1, win);
      @(negedge clk);
      if (win) begin pend1 = 1'b0; req1_valid = 1'b0; end
      else begin pend0 = 1'b0; req0_valid = 1'b0; end
      finish_job(ref_sort(win ? t1 : t0), win, st0, mv0, lat);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    clr_delay = 0;

    // Timeout: rasterizer never raises done.
    @(negedge clk);
    hang = 1'b1;
    run_len = 5;
    jd0 = jd_cnt;
    t0 = rnd_tri();
    issue(1'b1, 1'b0, t0, '0, win);
    @(negedge clk);
    req0_valid = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
`ifdef VERTEX_SORT_EN
    exp_busy = 105;
`else
    exp_busy = 102;
`endif
    chk("timeout_busy_cycles", 96'(n), 96'(exp_busy));
    chk("timeout_err_set", 96'(timeout_err), 96'd1);
    chk("timeout_no_job_done", 96'(jd_cnt - jd0), 96'd0);
    chk("timeout_count_same", 96'(tri_count), 96'(mdl_count));
    hang = 1'b0;
    guard = 0;
    while (r_run && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    run_len = 6;
    st0 = start_cyc;
    mv0 = moved_cnt;
    t1 = rnd_tri();
    issue(1'b0, 1'b1, '0, t1, win);
    @(negedge clk);
    req1_valid = 1'b0;
    finish_job(ref_sort(t1), 1'b1, st0, mv0, lat);
    chk("timeout_err_sticky", 96'(timeout_err), 96'd1);

    // Reset while the job is in RUN.
    @(negedge clk);
    run_len = 20;
    t0 = rnd_tri();
    issue(1'b1, 1'b0, t0, '0, win);
    @(negedge clk);
    req0_valid = 1'b0;
    guard = 0;
    while (!(r_run && r_cnt == 2 && busy) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_reset_ctrl", {89'd0, busy, rast_start, job_done, timeout_err, grant_id,
                              req0_ready, req1_ready}, 96'd0);
    chk("midrun_reset_count", 96'(tri_count), 96'd0);
    chk("midrun_reset_bus", bus, 96'd0);
    rst = 1'b0;
    mdl_last = 1'b1;
    mdl_count = 0;
    run_len = 7;
    st0 = start_cyc;
    t1 = rnd_tri();
    issue(1'b0, 1'b1, '0, t1, win);
    @(negedge clk);
    req1_valid = 1'b0;
    mv0 = moved_cnt;
    finish_job(ref_sort(t1), 1'b1, st0, mv0, lat);

    chk("never_both_ready", 96'(both_rdy), 96'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tri_raster_sched.md
Name: tri_raster_sched

Overview:
- Schedules triangle jobs from two independent requesters onto the single shared scanline triangle rasterizer.
- Round-robin arbitration, captures the winning triangle, and optionally orders vertices by ascending x (the rasterizer requires x0 <= x1 <= x2).
- Drives the rasterizer's level-sampled start, tracks its sticky done flag, and reports per-job completion.
- Sits between the command front-end and the rasterizer/pixel-writer path.

Parameters:
- TIMEOUT_CYCLES, 24'd1000000: max cycles in RUN before the job is abandoned; 0 disables the timeout.
- CNT_W, 16: width of the completed-triangle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a triangle.
- req0_tri  in  96  packed {x0,y0,x1,y1,x2,y2}, 16 bits each, x0 at [95:80].
- req0_ready  out  1  transfer accepted when valid&ready.
- req1_valid  in  1  requester 1 has a triangle.
- req1_tri  in  96  same packing as req0_tri.
- req1_ready  out  1  transfer accepted when valid&ready.
- rast_x0, rast_y0, rast_x1, rast_y1, rast_x2, rast_y2  out  16 each  vertex bus to the rasterizer, held stable through the job.
- rast_start  out  1  start request to the rasterizer.
- rast_done  in  1  rasterizer done flag; sticky high after a job, cleared by the rasterizer when it accepts start.
- busy  out  1  high in any state except IDLE.
- grant_id  out  1  source of the current or last job.
- job_done  out  1  one-cycle pulse on normal completion.
- timeout_err  out  1  sticky; set on timeout, cleared only by rst.
- tri_count  out  CNT_W  completed-job count; wraps at 2^CNT_W.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - All rast_* vertex outputs = 0; rast_start = 0.
  - busy = 0, grant_id = 0, job_done = 0, timeout_err = 0, tri_count = 0.
  - last_grant = 1, so requester 0 wins the first tie.
- Reset mid-job: forces IDLE and drops rast_start. The rasterizer has no reset, so its in-flight job may still finish; the scheduler ignores that rast_done level, because the next job waits through ACK.
- Ready generation: reqN_ready is combinational and high only in IDLE for the arbitration winner. At most one ready is high per cycle.
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester != last_grant wins.
  - last_grant and grant_id update on the transfer cycle.
- IDLE: on transfer, latch the 96-bit triangle into the vertex registers and go to SORT (or LOAD if sorting is compiled out).
- SORT: three cycles, one compare-swap per cycle on the (x,y) pairs.
  - Order: swap(0,1), swap(1,2), swap(0,1).
  - Compare is unsigned on x only; equal x does not swap (stable).
  - Then go to LOAD.
- LOAD: one cycle; the vertex bus is now final. Go to START.
- START:
  - rast_start = 1 for exactly one cycle. The rasterizer samples start while idle and clears done on the following edge.
  - Go to ACK.
- ACK: wait until rast_done == 0, then go to RUN. This guards against the stale done from the previous job.
- RUN:
  - Count cycles.
  - On rast_done == 1: job_done pulses the next cycle, tri_count += 1, go to IDLE.
  - If the count reaches TIMEOUT_CYCLES (nonzero): set timeout_err, no job_done, no count, go to IDLE.
  - The ACK wait is also covered by the same counter.
- Timing: minimum transfer-to-job_done latency is 6 cycles with sort, 3 without, plus rasterizer runtime.
- Vertex bus stability: the vertex bus changes only in IDLE (latch) and SORT. It must not change from LOAD until the job leaves RUN.
- New transfers: none are accepted while busy. A requester holding valid keeps its request; there is no starvation, because the other requester wins the next tie.

Optional Feature:
- Macro VERTEX_SORT_EN.
  - Defined: SORT state present; vertices are reordered by ascending x as above.
  - Undefined: SORT is removed, IDLE goes straight to LOAD, and vertices pass through unmodified. Requesters must pre-sort.

Test Plan:
- Single request, req0_tri = {10,5, 20,30, 40,5}, rasterizer model done after 50 cycles -> rast_start pulses once, vertices unchanged, job_done pulse, tri_count = 1, grant_id = 0.
- Sorting (VERTEX_SORT_EN), req1_tri = {40,5, 10,5, 20,30} -> rast_x0/x1/x2 = 10/20/40 with y 5/30/5 by LOAD; equal-x input {7,1, 7,2, 3,9} -> x order 3,7,7 with y 9,1,2.
- Both valid continuously for 4 jobs -> grants 0,1,0,1; never both ready in one cycle; tri_count = 4.
- Stale done: rast_done held 1 at start, cleared 2 cycles after rast_start -> scheduler stays in ACK until the clear, then completes normally.
- TIMEOUT_CYCLES = 100, rast_done never rises -> timeout_err = 1 after 100 RUN cycles, busy = 0, no job_done, tri_count unchanged; next request still served.
- Assert rst during RUN -> next cycle all outputs at reset values, timeout_err = 0, state IDLE, a new request accepted immediately.
